// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the asynchronous SRAM controller:
//   - SRAM_AW / SRAM_DW / SRAM_BW : address, data and byte-enable widths
//   - CNT_W                       : width of the per-state cycle counter
//   - state_t                     : controller FSM states
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

   localparam int SRAM_AW = 20;
   localparam int SRAM_DW = 32;
   localparam int SRAM_BW = SRAM_DW / 8;
   localparam int CNT_W   = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD       = 3'd1,
      WR_SETUP = 3'd2,
      WR_PULSE = 3'd3,
      WR_HOLD  = 3'd4
   } state_t;

endpackage : sram_ctrl_pkg

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// Single-port request/response front end for an asynchronous SRAM.
// One access is in flight at a time; the controller sequences the SRAM
// strobes for a timed read or a setup/pulse/hold write and then returns a
// one-cycle completion pulse.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready is high only while idle. rsp_valid is a
// one-cycle pulse with no backpressure; it always falls in an idle cycle, so
// a new request can be accepted in that same cycle.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   req_valid / req_ready  : request handshake
//   req_we                 : 1 = write, 0 = read
//   req_addr               : word address (SRAM_AW bits)
//   req_wdata / req_wstrb  : write data and active-high byte enables
//   rsp_valid / rsp_rdata  : completion pulse and last captured read data
//   ram_data               : bidirectional SRAM data bus
//   ram_addr / ram_be_n    : SRAM address and active-low byte enables
//   ram_ce_n/oe_n/we_n     : active-low chip enable, output enable, write enable
//   dbg_state              : current FSM state, for observation only
//
// RD_CYCLES / WR_CYCLES must lie in 1..15 (they are loaded into a 4-bit
// counter as N-1).
// -----------------------------------------------------------------------------
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int RD_CYCLES = 2,
   parameter int WR_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [SRAM_AW-1:0]  req_addr,
   input  logic [SRAM_DW-1:0]  req_wdata,
   input  logic [SRAM_BW-1:0]  req_wstrb,
   output logic                rsp_valid,
   output logic [SRAM_DW-1:0]  rsp_rdata,
   inout  wire  [SRAM_DW-1:0]  ram_data,
   output logic [SRAM_AW-1:0]  ram_addr,
   output logic [SRAM_BW-1:0]  ram_be_n,
   output logic                ram_ce_n,
   output logic                ram_oe_n,
   output logic                ram_we_n,
   output state_t              dbg_state
);

   // The counter holds "cycles remaining after this one", so a state lasting
   // N cycles is entered with N-1 and left when the counter reads zero.
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [SRAM_AW-1:0]   r_addr;
   logic [SRAM_DW-1:0]   r_wdata;
   logic [SRAM_BW-1:0]   r_be_n;
   logic [SRAM_DW-1:0]   r_rdata;
   logic                 r_rsp_valid;

   state_t               w_state_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 w_accept;
   logic                 w_capture;
   logic                 w_done;
   logic                 w_drive;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      // Saturating decrement: the counter parks at zero instead of wrapping.
      w_cnt_nxt   = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_done      = 1'b0;

      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_accept = 1'b1;
               if (req_we) begin
                  w_state_nxt = WR_SETUP;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = RD;
                  w_cnt_nxt   = RD_LOAD;
               end
            end
         end
         RD: begin
            if (r_cnt == '0) begin
               // Last read cycle: the data bus is sampled on this edge.
               w_capture   = 1'b1;
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         WR_SETUP: begin
            w_state_nxt = WR_PULSE;
            w_cnt_nxt   = WR_LOAD;
         end
         WR_PULSE: begin
            if (r_cnt == '0) begin
               w_state_nxt = WR_HOLD;
               w_cnt_nxt   = '0;
            end
         end
         WR_HOLD: begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be_n      <= '1;
         r_rdata     <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rsp_valid <= w_done;
         if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            // Reads enable every byte lane.
            r_be_n  <= req_we ? ~req_wstrb : '0;
         end
         if (w_capture) begin
            r_rdata <= ram_data;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Strobes are decoded straight from the state register. oe_n is low only
   // in RD and we_n only in WR_PULSE, so they can never be low together, and
   // the bus is only driven in write states where oe_n is high.
   // ---------------------------------------------------------------------------
   assign w_drive   = (r_state == WR_SETUP) || (r_state == WR_PULSE) ||
                      (r_state == WR_HOLD);

   assign req_ready = (r_state == IDLE);
   assign ram_ce_n  = (r_state == IDLE);
   assign ram_oe_n  = (r_state != RD);
   assign ram_we_n  = (r_state != WR_PULSE);
   assign ram_be_n  = (r_state == IDLE) ? '1 : r_be_n;
   assign ram_addr  = r_addr;

   assign ram_data  = w_drive ? r_wdata : {SRAM_DW{1'bz}};

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign dbg_state = r_state;

endmodule : sram_ctrl

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
// Directed bench for sram_ctrl (RD_CYCLES = WR_CYCLES = 2) with a behavioural
// asynchronous SRAM on the data bus. Inputs are driven and outputs sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

   localparam int RD_CYC = 2;
   localparam int WR_CYC = 2;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #10 clk = ~clk;   // 50 MHz

   logic        req_valid = 1'b0;
   logic        req_we    = 1'b0;
   logic [19:0] req_addr  = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   wire  [31:0] ram_data;
   logic [19:0] ram_addr;
   logic [3:0]  ram_be_n;
   logic        ram_ce_n;
   logic        ram_oe_n;
   logic        ram_we_n;
   state_t      dbg_state;

   sram_ctrl #(.RD_CYCLES(RD_CYC), .WR_CYCLES(WR_CYC)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .ram_data  (ram_data),
      .ram_addr  (ram_addr),
      .ram_be_n  (ram_be_n),
      .ram_ce_n  (ram_ce_n),
      .ram_oe_n  (ram_oe_n),
      .ram_we_n  (ram_we_n),
      .dbg_state (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Behavioural SRAM (256 words, no init file): drives the bus while read
   // enabled, stores enabled bytes on each clock edge seen with we_n low.
   // ---------------------------------------------------------------------------
   logic [31:0] mem [0:255];
   initial for (int i = 0; i < 256; i++) mem[i] = '0;

   assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr[7:0]] : 32'bz;

   always @(posedge clk) begin
      if (!ram_ce_n && !ram_we_n) begin
         for (int b = 0; b < 4; b++)
            if (!ram_be_n[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_viol   = 0;
   logic [31:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Every-cycle protocol monitor, summarised in one comparison at the end.
   always @(negedge clk) begin
      if (!rst) begin
         if (!ram_oe_n && !ram_we_n) n_viol++;
         if ((dbg_state inside {WR_SETUP, WR_PULSE, WR_HOLD}) && !ram_oe_n) n_viol++;
         if (req_ready != (dbg_state == IDLE)) n_viol++;
         if (rsp_valid && (dbg_state != IDLE)) n_viol++;
      end
   end

   // ---------------------------------------------------------------------------
   // Driver: one request with a cycle-by-cycle check of the strobe sequence.
   // Called and returns on a falling edge.
   // ---------------------------------------------------------------------------
   task automatic do_req(input logic we, input logic [19:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp_rd, input string tag);
      int         n;
      int         total;
      logic [2:0] exp_str;
      logic [3:0] exp_be;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = s;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
      if (!we) exp_q.push_back(exp_rd);
      @(negedge clk);
      req_valid = 1'b0;
      total  = we ? 3 + WR_CYC : 1 + RD_CYC;
      exp_be = we ? ~s : 4'h0;
      for (int k = 1; k < total; k++) begin
         if (!we)                          exp_str = 3'b001;
         else if (k == 1 || k == total-1)  exp_str = 3'b011;
         else                              exp_str = 3'b010;
         check_val({tag, "_strb"}, 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'(exp_str));
         check_val({tag, "_be"},   32'(ram_be_n), 32'(exp_be));
         check_val({tag, "_addr"}, 32'(ram_addr), 32'(a));
         check_val({tag, "_early_rsp"}, 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      check_val({tag, "_rsp"},       32'(rsp_valid), 32'd1);
      check_val({tag, "_idle_strb"}, 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);
      check_val({tag, "_idle_be"},   32'(ram_be_n), 32'hF);
      check_val({tag, "_addr_hold"}, 32'(ram_addr), 32'(a));
      if (!we && exp_q.size() > 0) check_val({tag, "_rdata"}, rsp_rdata, exp_q.pop_front());
      @(negedge clk);
      check_val({tag, "_rsp_once"}, 32'(rsp_valid), 32'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      int   n;
      logic seen;

      // Reset for 3 cycles; check while rst is still high (cycle after an rst edge).
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_ready",  32'(req_ready), 32'd1);
      check_val("rst_rsp",    32'(rsp_valid), 32'd0);
      check_val("rst_rdata",  rsp_rdata, 32'h0);
      check_val("rst_strb",   32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);
      check_val("rst_be",     32'(ram_be_n), 32'hF);
      check_val("rst_addr",   32'(ram_addr), 32'h0);
      check_val("rst_state",  32'(dbg_state), 32'(IDLE));
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_ready", 32'(req_ready), 32'd1);

      // Full-word write then read back.
      do_req(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, 32'h0, "wr_full");
      do_req(1'b0, 20'h00010, 32'h0, 4'h0, 32'hDEADBEEF, "rd_full");

      // Single-byte write on lane 1.
      do_req(1'b1, 20'h00010, 32'h0000AB00, 4'b0010, 32'h0, "wr_byte1");
      do_req(1'b0, 20'h00010, 32'h0, 4'h0, 32'hDEADABEF, "rd_byte1");

      // Back-to-back alternating requests with req_valid held high.
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_we    = (i % 2 == 0);
         req_addr  = (i < 2) ? 20'h00030 : 20'h00031;
         req_wdata = (i < 2) ? 32'h11223344 : 32'h55667788;
         req_wstrb = 4'hF;
         n = 0;
         while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         check_val("b2b_ready", 32'(req_ready), 32'd1);
         if (i > 0) check_val("b2b_acc_in_rsp", 32'(rsp_valid), 32'd1);
         if (i == 2) check_val("b2b_rd0", rsp_rdata, 32'h11223344);
         @(negedge clk);
      end
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("b2b_last_rsp", 32'(rsp_valid), 32'd1);
      check_val("b2b_rd1", rsp_rdata, 32'h55667788);
      @(negedge clk);

      // Reset during the second write-pulse cycle.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 20'h00020;
      req_wdata = 32'hCAFEF00D;
      req_wstrb = 4'hF;
      @(negedge clk);              // setup cycle
      req_valid = 1'b0;
      @(negedge clk);              // first pulse cycle
      @(negedge clk);              // second pulse cycle
      check_val("abort_in_pulse", 32'(ram_we_n), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_val("abort_strb",  32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);
      check_val("abort_state", 32'(dbg_state), 32'(IDLE));
      check_val("abort_rsp",   32'(rsp_valid), 32'd0);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check_val("abort_no_rsp", 32'(seen), 32'd0);
      do_req(1'b0, 20'h00010, 32'h0, 4'h0, 32'hDEADABEF, "rd_after_abort");

      // Write with no byte enables: full sequence, memory and rdata unchanged.
      do_req(1'b1, 20'h00010, 32'h12345678, 4'h0, 32'h0, "wr_strb0");
      check_val("wr_strb0_rdata_hold", rsp_rdata, 32'hDEADABEF);
      do_req(1'b0, 20'h00010, 32'h0, 4'h0, 32'hDEADABEF, "rd_after_strb0");

      check_val("oe_we_excl", 32'(n_viol), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Watchdog against a hung run.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule : tb_sram_ctrl

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter RD_CYCLES, default 2, number of clock cycles ram_ce_n/ram_oe_n are held low per read (legal range 1..15).
REQ-002 Parameter WR_CYCLES, default 2, number of clock cycles ram_we_n is held low per write (legal range 1..15).
REQ-003 The block SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when high with req_valid.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  20  word address.
REQ-010 req_wdata  input  32  write data.
REQ-011 req_wstrb  input  4  byte enables, active-high.
REQ-012 rsp_valid  output  1  one-cycle completion pulse (no backpressure).
REQ-013 rsp_rdata  output  32  read data, valid with rsp_valid after a read.
REQ-014 ram_data  inout  32  SRAM data bus.
REQ-015 ram_addr  output  20  SRAM address.
REQ-016 ram_be_n  output  4  byte enables, active-low.
REQ-017 ram_ce_n, ram_oe_n, ram_we_n  output  1 each  chip select, read enable, write enable, all active-low.

Function
REQ-018 FSM states SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD; req_ready SHALL be high only in IDLE.
REQ-019 On acceptance (cycle T), addr/wdata/wstrb/we SHALL be latched; ram_addr and ram_be_n (= ~wstrb for writes, 4'h0 for reads) SHALL be driven from T+1 until return to IDLE.
REQ-020 Read: RD for RD_CYCLES cycles with ram_ce_n=0, ram_oe_n=0, ram_we_n=1, bus released; ram_data SHALL be captured at the final RD clock edge; rsp_valid=1 and rsp_rdata valid in cycle T+1+RD_CYCLES.
REQ-021 Write: WR_SETUP 1 cycle (ce_n=0, we_n=1, data driven); WR_PULSE WR_CYCLES cycles (we_n=0); WR_HOLD 1 cycle (we_n=1, ce_n=0, data still driven); rsp_valid=1 in cycle T+3+WR_CYCLES.
REQ-022 ram_oe_n SHALL be 1 in every cycle the block drives ram_data; ram_oe_n and ram_we_n SHALL never both be 0.
REQ-023 The rsp_valid cycle SHALL be an IDLE cycle, so req_ready is high in it and a back-to-back request can be accepted there.
REQ-024 A write with req_wstrb=4'h0 SHALL run the full write sequence with ram_be_n=4'hF and still return rsp_valid.
REQ-025 rsp_rdata SHALL hold its last captured value; writes SHALL NOT alter it.
REQ-026 The cycle counter SHALL be 4 bits, loaded on state entry, and SHALL decrement to zero without wrap-around.
REQ-027 In IDLE: ce_n=oe_n=we_n=1, be_n=4'hF, ram_data high-Z, ram_addr holds its last value.

Reset
REQ-028 With rst high at a clock edge, the next cycle SHALL show: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, ram_ce_n/oe_n/we_n=1, ram_be_n=4'hF, ram_addr=0, ram_data high-Z.
REQ-029 Reset mid-operation SHALL abort the access, drop the request without any response, and deassert all strobes at the next edge.

Structure
REQ-030 Package sram_ctrl_pkg SHALL hold the state enum, SRAM_AW=20, SRAM_DW=32 and the counter width.
REQ-031 No sub-module is needed; the ram_data tristate SHALL be a single continuous assign in sram_ctrl.

Verification (bench: behavioural async SRAM model, Init_File "none", 50 MHz clk)
REQ-032 Reset for 3 cycles -> all outputs at the REQ-028 values; req_ready=1 on the first cycle after reset.
REQ-033 Write addr 0x00010, data 0xDEADBEEF, wstrb 4'hF, then read 0x00010 -> rsp_rdata=0xDEADBEEF, with read rsp_valid exactly 3 cycles after acceptance (RD_CYCLES=2).
REQ-034 Write 0x0000AB00 with wstrb 4'b0010 to 0x00010, then read -> 0xDEADABEF.
REQ-035 req_valid held high across 4 alternating write/read requests -> each accepted in the preceding rsp_valid cycle; the REQ-022 assertion holds in every cycle.
REQ-036 rst pulsed in the 2nd WR_PULSE cycle -> next cycle we_n=1, ce_n=1, bus high-Z; no rsp_valid; a following read returns valid data.
REQ-037 Write with wstrb 4'h0 to 0x00010 -> rsp_valid pulses once; a subsequent read returns the unchanged 0xDEADABEF.
